// File: rtl/packet_gen.sv
// packet_gen: ingress-side packet generator.
// Metadata words (src, dest, length) are queued in a small FIFO and each
// entry is serialized into a switch-format packet: length+DMAC, timestamp,
// SMAC, then all-ones payload. A valid/ready handshake applies backpressure.
module packet_gen #(
    parameter int META_DEPTH = 8,
    parameter int META_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [META_WIDTH-1:0] meta_in,
    input  logic                  meta_in_en,
    output logic                  meta_full,
    output logic [31:0]           ingress_out,
    output logic                  ingress_out_en,
    input  logic                  ingress_out_ready,
    output logic                  ingress_out_last,
    output logic [15:0]           pkt_sent_cnt
);

    localparam int PTR_W = (META_DEPTH > 1) ? $clog2(META_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    // Word w of a packet; idx counts 32-bit words from the start of the packet.
    function automatic logic [31:0] pkt_word(
        input logic [8:0]  idx,
        input logic [5:0]  blocks,
        input logic [1:0]  src,
        input logic [1:0]  dest,
        input logic [31:0] ts
    );
        logic [15:0] len_bytes;
        logic [31:0] word;
        len_bytes = {4'b0000, ({1'b0, blocks} + 7'd1), 5'b00000};
        case (idx)
            9'd0:    word = {len_bytes, 16'h0200};
            9'd1:    word = {30'h0000_0000, dest};
            9'd2:    word = ts;
            9'd3:    word = 32'h0000_0000;
            9'd4:    word = 32'h0200_0000;
            9'd5:    word = {14'h0000, src, 16'h0000};
            default: word = 32'hFFFF_FFFF;
        endcase
        return word;
    endfunction

    // FIFO storage keeps only the meaningful low 12 metadata bits
    logic [11:0]      mem_r [META_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             full_r;
    logic             empty_s;
    logic             wr_s;
    logic             pop_s;
    logic             xfer_s;
    logic             end_pkt_s;
    logic [11:0]      head_s;

    // Packet serializer state
    logic [0:0]  state_r;
    logic [5:0]  blocks_r;
    logic [1:0]  src_r;
    logic [1:0]  dest_r;
    logic [31:0] ts_r;
    logic [8:0]  idx_r;
    logic [31:0] word_r;
    logic        en_r;
    logic        last_r;
    logic [15:0] cnt_r;
    logic [31:0] now_r;

    // Next-word selection: a pop starts a fresh packet, otherwise advance
    logic [5:0]  sel_blocks_s;
    logic [1:0]  sel_src_s;
    logic [1:0]  sel_dest_s;
    logic [31:0] sel_ts_s;
    logic [8:0]  idx_nxt_s;
    logic [31:0] word_nxt_s;
    logic        last_nxt_s;

    // Metadata bits above [11:0] carry no meaning for this block
    logic        meta_unused_s;
    assign meta_unused_s = ^meta_in[META_WIDTH-1:12];

    assign head_s    = mem_r[rd_ptr_r];
    assign empty_s   = (count_r == CNT_W'(0));
    assign wr_s      = meta_in_en && !full_r;
    assign xfer_s    = en_r && ingress_out_ready;
    assign end_pkt_s = xfer_s && last_r;
    assign pop_s     = !empty_s && ((state_r == ST_IDLE) || end_pkt_s);

    // Occupancy update; a simultaneous push and pop leaves the count unchanged
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Select the packet fields and word index for the word presented next
    always_comb begin
        sel_blocks_s = blocks_r;
        sel_src_s    = src_r;
        sel_dest_s   = dest_r;
        sel_ts_s     = ts_r;
        idx_nxt_s    = idx_r + 9'd1;
        if (pop_s) begin
            sel_blocks_s = head_s[5:0];
            sel_src_s    = head_s[11:10];
            sel_dest_s   = head_s[9:8];
            sel_ts_s     = now_r;
            idx_nxt_s    = 9'd0;
        end else begin
            sel_blocks_s = blocks_r;
            sel_src_s    = src_r;
            sel_dest_s   = dest_r;
            sel_ts_s     = ts_r;
            idx_nxt_s    = idx_r + 9'd1;
        end
        word_nxt_s = pkt_word(idx_nxt_s, sel_blocks_s, sel_src_s, sel_dest_s, sel_ts_s);
        last_nxt_s = (idx_nxt_s == {sel_blocks_s, 3'b111});
    end

    // Metadata FIFO: storage, wrapping pointers, count and registered full flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < META_DEPTH; i++) begin
                mem_r[i] <= 12'h000;
            end
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
            full_r   <= 1'b0;
        end else begin
            if (wr_s) begin
                mem_r[wr_ptr_r] <= meta_in[11:0];
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CNT_W'(META_DEPTH));
        end
    end

    // Serializer FSM: load a packet on pop, advance on transfer, idle when drained
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            blocks_r <= 6'd0;
            src_r    <= 2'd0;
            dest_r   <= 2'd0;
            ts_r     <= 32'h0000_0000;
            idx_r    <= 9'd0;
            word_r   <= 32'h0000_0000;
            en_r     <= 1'b0;
            last_r   <= 1'b0;
        end else if (pop_s) begin
            state_r  <= ST_SEND;
            blocks_r <= sel_blocks_s;
            src_r    <= sel_src_s;
            dest_r   <= sel_dest_s;
            ts_r     <= sel_ts_s;
            idx_r    <= idx_nxt_s;
            word_r   <= word_nxt_s;
            en_r     <= 1'b1;
            last_r   <= last_nxt_s;
        end else if (end_pkt_s) begin
            state_r <= ST_IDLE;
            idx_r   <= 9'd0;
            word_r  <= 32'h0000_0000;
            en_r    <= 1'b0;
            last_r  <= 1'b0;
        end else if (xfer_s) begin
            idx_r  <= idx_nxt_s;
            word_r <= word_nxt_s;
            last_r <= last_nxt_s;
        end else begin
            state_r <= state_r;
            idx_r   <= idx_r;
            word_r  <= word_r;
            en_r    <= en_r;
            last_r  <= last_r;
        end
    end

    // Count fully transferred packets; wraps naturally at 16 bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= 16'h0000;
        end else if (end_pkt_s) begin
            cnt_r <= cnt_r + 16'h0001;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Free-running timestamp source
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            now_r <= 32'h0000_0000;
        end else begin
            now_r <= now_r + 32'h0000_0001;
        end
    end

    assign meta_full        = full_r;
    assign ingress_out      = word_r;
    assign ingress_out_en   = en_r;
    assign ingress_out_last = last_r;
    assign pkt_sent_cnt     = cnt_r;

endmodule

// File: tb/tb_packet_gen.sv
// Testbench for packet_gen: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level queue model.
module tb_packet_gen;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] meta_in;
    logic        meta_in_en;
    logic        meta_full;
    logic [31:0] ingress_out;
    logic        ingress_out_en;
    logic        ingress_out_ready;
    logic        ingress_out_last;
    logic [15:0] pkt_sent_cnt;

    packet_gen #(.META_DEPTH(DEPTH), .META_WIDTH(32)) dut (
        .clk               (clk),
        .reset             (reset),
        .meta_in           (meta_in),
        .meta_in_en        (meta_in_en),
        .meta_full         (meta_full),
        .ingress_out       (ingress_out),
        .ingress_out_en    (ingress_out_en),
        .ingress_out_ready (ingress_out_ready),
        .ingress_out_last  (ingress_out_last),
        .pkt_sent_cnt      (pkt_sent_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [11:0] mq[$];
    logic [31:0] exp_q[$];
    logic [31:0] model_now;
    logic [15:0] model_cnt;
    int          cur_idx;
    bit          chk_on;
    bit          rnd_ready;
    logic [31:0] seen_q[$];
    bit          seen_last_q[$];
    logic [31:0] exp_single[8];
    int          exp_total;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected word list of one packet, straight from the packet format rules
    function automatic void build(input logic [11:0] m, input logic [31:0] ts);
        int blk;
        int nwords;
        logic [31:0] len;
        blk    = int'(m[5:0]) + 1;
        len    = 32'(blk * 32);
        nwords = blk * 32 / 4;
        for (int w = 0; w < nwords; w++) begin
            case (w)
                0:       exp_q.push_back((len << 16) | 32'h0000_0200);
                1:       exp_q.push_back(32'(m[9:8]));
                2:       exp_q.push_back(ts);
                3:       exp_q.push_back(32'h0);
                4:       exp_q.push_back(32'h0200_0000);
                5:       exp_q.push_back(32'(m[11:10]) << 16);
                default: exp_q.push_back(32'hFFFF_FFFF);
            endcase
        end
    endfunction

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        model_now = 32'h0;
        model_cnt = 16'h0;
        cur_idx   = 0;
    endtask

    // Per-cycle comparison against the model, then advance the model one cycle
    always @(negedge clk) begin
        if (chk_on) begin
            bit busy;
            bit xfer;
            bit pop;
            bit wr;
            busy = (exp_q.size() > 0);
            check("en", 32'(ingress_out_en), 32'(busy));
            if (busy) begin
                check("word", ingress_out, exp_q[0]);
                check("last", 32'(ingress_out_last), 32'(exp_q.size() == 1));
            end else begin
                check("last_idle", 32'(ingress_out_last), 32'h0);
            end
            check("full", 32'(meta_full), 32'(mq.size() == DEPTH));
            check("cnt", 32'(pkt_sent_cnt), 32'(model_cnt));
            xfer = busy && ingress_out_ready;
            pop  = (mq.size() > 0) && (!busy || (xfer && exp_q.size() == 1));
            wr   = meta_in_en && (mq.size() < DEPTH);
            if (xfer) begin
                seen_q.push_back(ingress_out);
                seen_last_q.push_back(ingress_out_last);
                void'(exp_q.pop_front());
                cur_idx++;
                if (exp_q.size() == 0) model_cnt = model_cnt + 16'h1;
            end
            if (pop) begin
                build(mq.pop_front(), model_now);
                cur_idx = 0;
            end
            if (wr) mq.push_back(meta_in[11:0]);
            model_now = model_now + 32'h1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        meta_in_en = 1'b0;
        if (rnd_ready) ingress_out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic write_meta(input logic [31:0] m);
        meta_in    = m;
        meta_in_en = 1'b1;
        tick();
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (mq.size() == 0 && exp_q.size() == 0) break;
            tick();
        end
        check("drain_timeout", 32'(mq.size() + exp_q.size()), 32'h0);
    endtask

    task automatic clear_seen();
        seen_q.delete();
        seen_last_q.delete();
    endtask

    initial begin
        logic [31:0] m;
        int          nlast;
        exp_single[0] = 32'h0020_0200;
        exp_single[1] = 32'h0000_0000;
        exp_single[2] = 32'h0000_0001;
        exp_single[3] = 32'h0000_0000;
        exp_single[4] = 32'h0200_0000;
        exp_single[5] = 32'h0001_0000;
        exp_single[6] = 32'hFFFF_FFFF;
        exp_single[7] = 32'hFFFF_FFFF;
        reset             = 1'b0;
        meta_in           = 32'h0;
        meta_in_en        = 1'b0;
        ingress_out_ready = 1'b1;
        chk_on            = 1'b0;
        rnd_ready         = 1'b0;
        exp_total         = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", ingress_out, 32'h0);
        check("rst_en", 32'(ingress_out_en), 32'h0);
        check("rst_last", 32'(ingress_out_last), 32'h0);
        check("rst_full", 32'(meta_full), 32'h0);
        check("rst_cnt", 32'(pkt_sent_cnt), 32'h0);
        reset  = 1'b1;
        model_reset();
        chk_on = 1'b1;

        // Single one-block packet, popped when now == 1
        clear_seen();
        write_meta(32'h0000_0400);
        wait_drain(100);
        exp_total += 1;
        check("single_len", 32'(seen_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < seen_q.size(); i++) begin
            check("single_word", seen_q[i], exp_single[i]);
            check("single_last", 32'(seen_last_q[i]), 32'(i == 7));
        end
        check("single_cnt", 32'(pkt_sent_cnt), 32'(exp_total));

        // Maximum length, dest 3, junk in upper metadata bits
        clear_seen();
        write_meta(32'hABCD_F33F);
        wait_drain(700);
        exp_total += 1;
        check("max_len", 32'(seen_q.size()), 32'd512);
        if (seen_q.size() == 512) begin
            check("max_w0", seen_q[0], 32'h0800_0200);
            check("max_w1", seen_q[1], 32'h0000_0003);
            check("max_last_pos", 32'(seen_last_q[511]), 32'h1);
        end
        nlast = 0;
        foreach (seen_last_q[i]) nlast += int'(seen_last_q[i]);
        check("max_last_cnt", 32'(nlast), 32'h1);

        // Random backpressure on a three-block packet
        rnd_ready = 1'b1;
        clear_seen();
        write_meta(32'h0000_0C02);
        wait_drain(400);
        exp_total += 1;
        check("bp_len", 32'(seen_q.size()), 32'd24);
        rnd_ready         = 1'b0;
        ingress_out_ready = 1'b1;

        // Back-to-back one-block packets
        clear_seen();
        write_meta(32'h0000_0100);
        write_meta(32'h0000_0600);
        write_meta(32'h0000_0B00);
        wait_drain(200);
        exp_total += 3;
        check("b2b_len", 32'(seen_q.size()), 32'd24);
        if (seen_q.size() == 24) begin
            check("b2b_ts_order", 32'(seen_q[10] > seen_q[2] && seen_q[18] > seen_q[10]), 32'h1);
        end
        check("b2b_cnt", 32'(pkt_sent_cnt), 32'(exp_total));

        // Fill the FIFO while stalled; the last write is dropped
        ingress_out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            m = $urandom();
            m[5:0] = 6'd0;
            write_meta(m);
        end
        check("full_high", 32'(meta_full), 32'h1);
        ingress_out_ready = 1'b1;
        wait_drain(400);
        exp_total += DEPTH + 1;
        check("full_cnt", 32'(pkt_sent_cnt), 32'(exp_total));

        // Randomized traffic with random ready and write gaps
        rnd_ready = 1'b1;
        for (int p = 0; p < 12; p++) begin
            m = $urandom();
            m[5:3] = 3'd0;
            write_meta(m);
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_drain(3000);
        rnd_ready         = 1'b0;
        ingress_out_ready = 1'b1;

        // Reset while word 3 of a packet is on the bus
        write_meta(32'h0000_0501);
        write_meta(32'h0000_0000);
        for (int i = 0; i < 100; i++) begin
            if (cur_idx == 3 && exp_q.size() > 0) break;
            tick();
        end
        check("mid_reached", 32'(cur_idx), 32'd3);
        chk_on = 1'b0;
        reset  = 1'b0;
        #1;
        check("abort_en", 32'(ingress_out_en), 32'h0);
        check("abort_last", 32'(ingress_out_last), 32'h0);
        check("abort_cnt", 32'(pkt_sent_cnt), 32'h0);
        check("abort_full", 32'(meta_full), 32'h0);
        repeat (2) tick();
        reset  = 1'b1;
        model_reset();
        chk_on = 1'b1;
        repeat (20) tick();
        check("post_rst_en", 32'(ingress_out_en), 32'h0);
        check("post_rst_cnt", 32'(pkt_sent_cnt), 32'h0);
        clear_seen();
        write_meta(32'h0000_0900);
        wait_drain(100);
        check("recover_len", 32'(seen_q.size()), 32'd8);
        check("recover_cnt", 32'(pkt_sent_cnt), 32'h1);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
